// File: rtl/morse_pattern_tx.sv
// Morse/on-off pattern transmitter: plays a left-justified bit pattern MSB-first
// on one LED, one bit per TICK_DIV clocks, with optional gap-separated repeat.
module morse_pattern_tx #(
    parameter int TICK_DIV  = 25_000_000,
    parameter int PAT_W     = 16,
    parameter int GAP_UNITS = 7,
    localparam int LEN_W    = $clog2(PAT_W + 1)
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [PAT_W-1:0] i_pattern,
    input  logic [LEN_W-1:0] i_length,
    input  logic             i_repeat_en,
    input  logic             i_abort,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_led,
    output logic             o_done
);

    localparam int DIV_W = $clog2(TICK_DIV) + 1;
    localparam int GAP_W = $clog2(GAP_UNITS) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_UNITS - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [PAT_W-1:0]   r_shreg, w_shreg_next;
    logic [PAT_W-1:0]   r_pat_sh, w_pat_sh_next;
    logic [LEN_W-1:0]   r_cnt, w_cnt_next;
    logic [LEN_W-1:0]   r_len_sh, w_len_sh_next;
    logic [DIV_W-1:0]   r_div, w_div_next;
    logic [GAP_W-1:0]   r_gap, w_gap_next;
    logic               r_led, w_led_next;
    logic               r_done, w_done_next;
    logic               r_ready, r_busy;
    logic               w_tick;
    logic [LEN_W-1:0]   w_len_clamped;

    assign w_tick        = (r_div == DIV_LAST);
    assign w_len_clamped = (i_length > LEN_MAX) ? LEN_MAX : i_length;

    // State register plus all datapath/output registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_pat_sh <= '0;
            r_cnt    <= '0;
            r_len_sh <= '0;
            r_div    <= '0;
            r_gap    <= '0;
            r_led    <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_shreg  <= w_shreg_next;
            r_pat_sh <= w_pat_sh_next;
            r_cnt    <= w_cnt_next;
            r_len_sh <= w_len_sh_next;
            r_div    <= w_div_next;
            r_gap    <= w_gap_next;
            r_led    <= w_led_next;
            r_done   <= w_done_next;
            r_ready  <= (w_state_next == S_IDLE);
            r_busy   <= (w_state_next != S_IDLE);
        end
    end

    // Next-state and next-output logic; abort outranks everything but reset
    always_comb begin
        w_state_next  = r_state;
        w_shreg_next  = r_shreg;
        w_pat_sh_next = r_pat_sh;
        w_cnt_next    = r_cnt;
        w_len_sh_next = r_len_sh;
        w_div_next    = r_div;
        w_gap_next    = r_gap;
        w_led_next    = r_led;
        w_done_next   = 1'b0;

        if (i_abort) begin
            w_state_next = S_IDLE;
            w_led_next   = 1'b0;
            w_div_next   = '0;
            w_gap_next   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && r_ready) begin
                        w_shreg_next  = i_pattern;
                        w_pat_sh_next = i_pattern;
                        w_cnt_next    = w_len_clamped;
                        w_len_sh_next = w_len_clamped;
                        w_div_next    = '0;
                        if (w_len_clamped == '0) begin
                            w_done_next = 1'b1;
                            w_led_next  = 1'b0;
                        end else begin
                            w_state_next = S_SEND;
                            w_led_next   = i_pattern[PAT_W-1];
                        end
                    end else begin
                        w_led_next = 1'b0;
                    end
                end
                S_SEND: begin
                    if (w_tick) begin
                        w_div_next   = '0;
                        w_shreg_next = {r_shreg[PAT_W-2:0], 1'b0};
                        w_cnt_next   = r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            w_led_next = 1'b0;
                            // repeat_en is only looked at here, at the pattern end
                            if (i_repeat_en) begin
                                w_state_next = S_GAP;
                                w_gap_next   = '0;
                            end else begin
                                w_state_next = S_IDLE;
                                w_done_next  = 1'b1;
                            end
                        end else begin
                            w_led_next = r_shreg[PAT_W-2];
                        end
                    end else begin
                        w_div_next = r_div + DIV_W'(1);
                    end
                end
                S_GAP: begin
                    w_led_next = 1'b0;
                    if (w_tick) begin
                        w_div_next = '0;
                        if (r_gap == GAP_LAST) begin
                            w_state_next = S_SEND;
                            w_gap_next   = '0;
                            w_shreg_next = r_pat_sh;
                            w_cnt_next   = r_len_sh;
                            w_led_next   = r_pat_sh[PAT_W-1];
                        end else begin
                            w_gap_next = r_gap + GAP_W'(1);
                        end
                    end else begin
                        w_div_next = r_div + DIV_W'(1);
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_led_next   = 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_busy  = r_busy;
    assign o_led   = r_led;
    assign o_done  = r_done;

endmodule

// File: tb/tb_morse_pattern_tx.sv
// Scoreboard bench for morse_pattern_tx with TICK_DIV=4, PAT_W=16, GAP_UNITS=7.
module tb_morse_pattern_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  length;
    logic        repeat_en;
    logic        abort;
    logic        ready, busy, led, done;

    typedef struct packed {
        logic led;
        logic done;
        logic ready;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    morse_pattern_tx #(
        .TICK_DIV (4),
        .PAT_W    (16),
        .GAP_UNITS(7)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_start    (start),
        .i_pattern  (pattern),
        .i_length   (length),
        .i_repeat_en(repeat_en),
        .i_abort    (abort),
        .o_ready    (ready),
        .o_busy     (busy),
        .o_led      (led),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("led",   led,   e.led);
                check("done",  done,  e.done);
                check("ready", ready, e.ready);
                check("busy",  busy,  e.busy);
            end
        end
    end

    // One clock edge; push what the outputs must show after it
    task automatic step(input logic l, input logic d, input logic r, input logic b);
        @(posedge clk);
        #1;
        exp_q.push_back('{led: l, done: d, ready: r, busy: b});
    endtask

    task automatic expect_n(input int n, input logic l, input logic d, input logic r, input logic b);
        for (int i = 0; i < n; i++) step(l, d, r, b);
    endtask

    // Expect nbits hand-listed bits, 4 cycles each; first edge is the accepting one
    task automatic play(input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            for (int c = 0; c < 4; c++) begin
                step(bits[15-i], 1'b0, 1'b0, 1'b1);
                if (i == 0 && c == 0) start = 1'b0;
            end
        end
    endtask

    task automatic finish_job();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pattern = 16'h0000; length = 5'd0;
        repeat_en = 1'b0; abort = 1'b0;
        expect_n(2, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        expect_n(2, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset held 3 cycles in the middle of a send
        start = 1'b1; pattern = 16'hFFFF; length = 5'd16;
        play(16'hFFFF, 2);
        rst = 1'b1;
        expect_n(3, 1'b0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        expect_n(2, 1'b0, 1'b0, 1'b1, 1'b0);

        // Letter A: .- = 1,0,1,1,1
        start = 1'b1; pattern = 16'hB800; length = 5'd5;
        play(16'hB800, 5);
        finish_job();

        // Zero length: no send, done one cycle after accept
        start = 1'b1; pattern = 16'hFFFF; length = 5'd0;
        step(1'b0, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Length 20 clamps to 16 -> 64 cycles on
        start = 1'b1; pattern = 16'hFFFF; length = 5'd20;
        play(16'hFFFF, 16);
        finish_job();

        // Abort together with start in IDLE: start ignored
        start = 1'b1; abort = 1'b1; pattern = 16'h8000; length = 5'd1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b0; abort = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Auto-repeat: 4 on, 28 off, 4 on; repeat_en dropped mid-gap
        repeat_en = 1'b1;
        start = 1'b1; pattern = 16'h8000; length = 5'd1;
        play(16'h8000, 1);
        expect_n(28, 1'b0, 1'b0, 1'b0, 1'b1);
        play(16'h8000, 1);
        expect_n(14, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat_en = 1'b0;
        expect_n(14, 1'b0, 1'b0, 1'b0, 1'b1);
        play(16'h8000, 1);
        finish_job();

        // Abort on cycle 9 of a send, then restart one cycle later
        start = 1'b1; pattern = 16'hB800; length = 5'd5;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        expect_n(3, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_n(4, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        abort = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        abort = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b1; pattern = 16'hA000; length = 5'd3;
        play(16'hA000, 3);
        finish_job();

        // Start held while busy with another pattern: ignored
        start = 1'b1; pattern = 16'h9000; length = 5'd4;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        pattern = 16'h6000; length = 5'd2;
        expect_n(3, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_n(8, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_n(4, 1'b1, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        finish_job();

        // Back-to-back: start issued during the done cycle is accepted
        start = 1'b1; pattern = 16'h8000; length = 5'd1;
        play(16'h8000, 1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        start = 1'b1; pattern = 16'hC000; length = 5'd2;
        play(16'hC000, 2);
        finish_job();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
